// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory bus arbiter: FSM encoding, arbitration
// mode constants and a constant-width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACCESS  = 2'b10,
        ST_RELEASE = 2'b11
    } state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Smallest r with 2**r >= value; used to size counters and indices.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Rotating-base priority picker: the first set request strictly after
// 'base' (wrapping) wins. A base of N_REQ-1 gives plain lowest-index priority.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PW    = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    base,
    output logic [N_REQ-1:0] onehot,
    output logic [PW-1:0]    idx
);

    logic found;
    int   j;

    // Walk the requesters starting just after the base and take the first hit.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(base) + 1 + k) % N_REQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-requester arbiter for the shared 8-bit-core memory bus. One transaction
// at a time: IDLE picks an owner, ACCESS drives the bus until mem_ready or
// timeout, RELEASE drops mem_req for one cycle and either re-issues for a
// locked owner or frees the bus.
//
// Handshake: a requester holds req (and its addr/we/wdata slices) high until
// it sees its ready or err pulse; gnt shows the current owner. Toward memory,
// mem_req stays high with constant address/data until the cycle mem_ready is
// sampled high, then drops for at least one cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int ARB_MODE    = 0,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ-1:0]        req_lock,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ready,
    output logic [N_REQ-1:0]        err,
    output logic [DATA_W-1:0]       rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ready,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [1:0]              dbg_state
);

    localparam int PW = clog2(N_REQ);
    localparam int CW = clog2(TIMEOUT_CYC + 1);

    state_t           state;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    base;
    logic [N_REQ-1:0] pick_onehot;
    logic [PW-1:0]    pick_idx;

    assign dbg_state = state;

    // Fixed priority always searches from index 0; round-robin from after the last owner.
    assign base = (ARB_MODE == ARB_RR) ? ptr : PW'(N_REQ - 1);

    arb_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req    (req),
        .base   (base),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

    // Arbitration FSM with all bus and requester outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            owner     <= '0;
            ptr       <= PW'(N_REQ - 1);
            cnt       <= '0;
            gnt       <= '0;
            ready     <= '0;
            err       <= '0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ready <= '0;
            err   <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        owner     <= pick_idx;
                        gnt       <= pick_onehot;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we[pick_idx];
                        mem_addr  <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        cnt       <= '0;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        rdata   <= mem_rdata;
                        ready   <= gnt;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        ptr     <= owner;
                        state   <= ST_RELEASE;
                    end else if (cnt >= CW'(TIMEOUT_CYC)) begin
                        err     <= gnt;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= ST_RELEASE;
                    end else if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // A locked owner still requesting keeps the bus for another transaction.
                    if (req_lock[owner] && req[owner]) begin
                        mem_req   <= 1'b1;
                        mem_we    <= req_we[owner];
                        mem_addr  <= req_addr[int'(owner)*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[int'(owner)*DATA_W +: DATA_W];
                        cnt       <= '0;
                        state     <= ST_ACCESS;
                    end else begin
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-requester arbiter for the single shared memory bus of the 8-bit core family.
- Supersedes the hard-coded fetch/exec mux in the core top level.
- Adds selectable fixed or round-robin priority, multi-transaction bus lock, separated read/write data paths, and a per-transaction timeout.
- Sits between the pipeline stages (fetch, exec, future DMA) and the memory model or controller.

Parameters:
- N_REQ, 2, number of requesters (2..8); index 0 is exec, index 1 is fetch in the core.
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT_CYC, 255, max cycles to wait for mem_ready after mem_req rises (1..2^16-1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request; held high until its ready pulse.
- req_we  in  N_REQ  per-requester write enable, valid while req is high.
- req_lock  in  N_REQ  keep the grant after the current transaction completes.
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i = [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  packed write data.
- gnt  out  N_REQ  one-hot current owner; all zero when idle.
- ready  out  N_REQ  one-cycle completion pulse to the owner.
- err  out  N_REQ  one-cycle timeout pulse to the owner; replaces ready.
- rdata  out  DATA_W  read data registered on completion; valid when ready is high.
- mem_req  out  1  bus request to memory.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  DATA_W  bus write data.
- mem_ready  in  1  memory completion, one or more cycles high.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready.

Behaviour:

Reset (rst = 0, asynchronous):
- State goes to IDLE.
- gnt, ready, err, mem_req and mem_we are 0.
- mem_addr, mem_wdata and rdata are 0.
- The round-robin pointer is set to N_REQ-1, so index 0 is searched first.
- Timeout counter is 0.

States: IDLE, ACCESS, RELEASE.

IDLE:
- If any req is high, pick a winner:
  - ARB_MODE = 0: lowest set index.
  - ARB_MODE = 1: first set index after the pointer, wrapping.
- Next cycle: gnt = onehot(winner), mem_req = 1, mem_addr/mem_we/mem_wdata latched from the winner's slices. State -> ACCESS.
- Request-to-mem_req latency is exactly 1 cycle.

ACCESS:
- Bus outputs are held constant; the counter increments every cycle.
- On a cycle with mem_ready = 1:
  - Next cycle: rdata = mem_rdata (writes also capture it), ready[owner] = 1 for 1 cycle, mem_req = 0.
  - Pointer = owner.
  - State -> RELEASE.
- If the counter reaches TIMEOUT_CYC with no mem_ready:
  - err[owner] pulses for 1 cycle, mem_req drops, rdata is unchanged.
  - State -> RELEASE.

RELEASE (exactly 1 cycle, mem_req = 0, so memory always sees a request edge):
- If req_lock[owner] and req[owner] are both high: stay granted, re-latch the owner's address/we/wdata, mem_req = 1. State -> ACCESS; counter cleared.
- Otherwise gnt -> 0 and state -> IDLE. Arbitration resumes the cycle after.
- Minimum back-to-back transaction spacing is 2 idle bus cycles unlocked, 1 when locked.

Boundary rules:
- Owner drops req mid-ACCESS: the transaction still completes (memory cannot abort); ready pulses and is ignored; lock is not honoured.
- mem_ready high in IDLE or RELEASE: ignored.
- mem_ready held high across RELEASE: ignored until the next ACCESS has begun; no double completion.
- Simultaneous requests in round-robin mode: with a 2-requester continuous load, service strictly alternates.
- Fixed mode: starvation of higher indices is permitted and is intended.
- Address/data changes from the owner during ACCESS are ignored; latched values are used.
- Reset mid-ACCESS: immediate return to reset values; the transaction is lost.
- Width rules: the timeout counter is ceil(log2(TIMEOUT_CYC+1)) bits and saturates (no wrap). The round-robin pointer is ceil(log2(N_REQ)) bits and wraps to 0 after N_REQ-1.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE = 2'b00, ACCESS = 2'b10, RELEASE = 2'b11);
  - ARB_FIXED = 0 and ARB_RR = 1;
  - a clog2 helper function.
- One sub-module, arb_pick: a combinational rotating-base priority picker (inputs req and base, output onehot and index). Fixed mode ties base to N_REQ-1.

Test Plan:
1. Fixed mode, N_REQ = 2: req = 2'b11 in the same cycle, mem_ready after 2 cycles -> gnt = 01 first, then after RELEASE + IDLE gnt = 10. mem_addr follows slice 0, then slice 1.
2. Round-robin mode: both requesters held high for 6 transactions -> grant order 0,1,0,1,0,1; ready pulses alternate.
3. Read data: requester 1 reads addr 8'h10, memory returns 8'hA5 -> rdata = 8'hA5 on the same cycle ready[1] = 1; mem_we = 0 throughout.
4. Lock: fetch (index 1) raises req_lock for addr 8'h20 then 8'h21 while exec requests -> both fetch transactions complete before gnt[0] rises, with a 1-cycle mem_req gap between them.
5. Timeout: TIMEOUT_CYC = 4, mem_ready never asserted -> err[owner] pulses 5 cycles after mem_req rose, mem_req drops, and the next requester is granted.
6. Reset: rst taken low during ACCESS -> all outputs are 0 the same cycle; after release, the first grant goes to index 0 in both modes.
